// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg: shared CP0 exception definitions for the exception/ERET sequencer.
//   - exc_type bit indices as carried down the pipe from ID
//   - Cause.ExcCode values
//   - Status/Cause field positions
//   - default exception entry vector
//   - exc_sel_t: result of the fixed-priority exception pick
package exc_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'hBFC0_0380;

    // Bit positions inside mem_exc_type
    localparam int unsigned EXC_BIT_IF      = 0;
    localparam int unsigned EXC_BIT_RI      = 1;
    localparam int unsigned EXC_BIT_OV      = 2;
    localparam int unsigned EXC_BIT_TP      = 3;
    localparam int unsigned EXC_BIT_BREAK   = 4;
    localparam int unsigned EXC_BIT_SYSCALL = 5;
    localparam int unsigned EXC_BIT_ADE     = 6;
    localparam int unsigned EXC_BIT_ERET    = 7;

    // Cause.ExcCode values
    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;
    localparam logic [4:0] EXCCODE_TR   = 5'h0d;

    // Status field positions
    localparam int unsigned STATUS_IE    = 0;
    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned STATUS_IM_LO = 8;
    localparam int unsigned STATUS_IM_HI = 15;

    // Cause field positions
    localparam int unsigned CAUSE_BD         = 31;
    localparam int unsigned CAUSE_IP_LO      = 8;
    localparam int unsigned CAUSE_IP_HI      = 15;
    localparam int unsigned CAUSE_EXCCODE_LO = 2;
    localparam int unsigned CAUSE_EXCCODE_HI = 6;

    typedef struct packed {
        logic       hit;          // some event won
        logic       is_eret;      // the winner is ERET, not an exception
        logic [4:0] exc_code;     // Cause.ExcCode for an exception
        logic       use_badvaddr; // exception updates BadVAddr
        logic       badvaddr_sel; // 0: fetch PC (IF AdEL), 1: data address (ADE)
    } exc_sel_t;

endpackage

// File: rtl/exc_ctrl_priority_enc.sv
// exc_priority_enc: combinational fixed-priority pick among pending events.
//   exc_type    in  8  {eret, ade, syscall, break, tp, ov, ri, if}
//   int_pending in  1  an enabled, unmasked interrupt is pending
//   is_store    in  1  selects AdES over AdEL for a data address error
//   sel         out    exc_sel_t {hit, is_eret, exc_code, use_badvaddr, badvaddr_sel}
module exc_priority_enc
    import exc_ctrl_pkg::*;
(
    input  logic [7:0] exc_type,
    input  logic       int_pending,
    input  logic       is_store,
    output exc_sel_t   sel
);

    always_comb begin
        sel     = '0;
        sel.hit = 1'b1;
        if (int_pending) begin
            sel.exc_code = EXCCODE_INT;
        end else if (exc_type[EXC_BIT_IF]) begin
            sel.exc_code     = EXCCODE_ADEL;
            sel.use_badvaddr = 1'b1;
            sel.badvaddr_sel = 1'b0;
        end else if (exc_type[EXC_BIT_RI]) begin
            sel.exc_code = EXCCODE_RI;
        end else if (exc_type[EXC_BIT_OV]) begin
            sel.exc_code = EXCCODE_OV;
        end else if (exc_type[EXC_BIT_TP]) begin
            sel.exc_code = EXCCODE_TR;
        end else if (exc_type[EXC_BIT_SYSCALL]) begin
            sel.exc_code = EXCCODE_SYS;
        end else if (exc_type[EXC_BIT_BREAK]) begin
            sel.exc_code = EXCCODE_BP;
        end else if (exc_type[EXC_BIT_ADE]) begin
            sel.exc_code     = is_store ? EXCCODE_ADES : EXCCODE_ADEL;
            sel.use_badvaddr = 1'b1;
            sel.badvaddr_sel = 1'b1;
        end else if (exc_type[EXC_BIT_ERET]) begin
            // Lowest priority: any exception bit alongside eret wins above.
            sel.is_eret = 1'b1;
        end else begin
            sel.hit = 1'b0;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception / ERET sequencer at the MEM/CP0 boundary.
// Picks one event from the MEM-stage instruction (or a pending interrupt), then runs
// IDLE -> COMMIT (flush + CP0 write strobes) -> REDIRECT (hold redirect until if_ready).
//   clk, rst_n                     clock, async active-low reset
//   mem_valid/exc_type/pc/...      MEM-stage instruction and its exception info
//   cp0_status/cp0_ip/cp0_epc      current CP0 state
//   if_ready                       IF accepts the redirect this cycle
//   flush/stall_req                pipeline control
//   redirect_valid/redirect_pc     fetch redirect
//   cp0_*                          CP0 write strobes and data (COMMIT only)
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_W     = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0]      EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [7:0]        mem_exc_type,
    input  logic [ADDR_W-1:0] mem_pc,
    input  logic              mem_in_delay_slot,
    input  logic              mem_is_store,
    input  logic [ADDR_W-1:0] mem_badvaddr,
    input  logic [31:0]       cp0_status,
    input  logic [7:0]        cp0_ip,
    input  logic [ADDR_W-1:0] cp0_epc,
    input  logic              if_ready,
    output logic              flush,
    output logic              stall_req,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              cp0_exc_we,
    output logic              cp0_epc_we,
    output logic [4:0]        cp0_exc_code,
    output logic              cp0_bd,
    output logic [ADDR_W-1:0] cp0_epc_wdata,
    output logic              cp0_badvaddr_we,
    output logic [ADDR_W-1:0] cp0_badvaddr,
    output logic              cp0_eret
);

    typedef enum logic [1:0] {StIdle, StCommit, StRedirect} state_e;

    state_e            state_q;
    logic              eret_q;   // pending event is ERET (selects redirect target)
    logic              int_pending;
    logic              exl;
    exc_sel_t          sel;
    logic [ADDR_W-1:0] epc_val;
    logic [ADDR_W-1:0] bv_val;
    logic              unused_status;

    assign exl         = cp0_status[STATUS_EXL];
    assign int_pending = (|(cp0_ip & cp0_status[STATUS_IM_HI:STATUS_IM_LO]))
                         & cp0_status[STATUS_IE] & ~exl;
    assign unused_status = ^{cp0_status[31:STATUS_IM_HI+1], cp0_status[STATUS_IM_LO-1:2]};

    // A delay-slot instruction restarts at its branch.
    assign epc_val = mem_in_delay_slot ? (mem_pc - ADDR_W'(4)) : mem_pc;
    assign bv_val  = sel.badvaddr_sel ? mem_badvaddr : mem_pc;

    exc_priority_enc u_prio (
        .exc_type    (mem_exc_type),
        .int_pending (int_pending),
        .is_store    (mem_is_store),
        .sel         (sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            eret_q          <= 1'b0;
            flush           <= 1'b0;
            stall_req       <= 1'b0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
            cp0_exc_we      <= 1'b0;
            cp0_epc_we      <= 1'b0;
            cp0_exc_code    <= '0;
            cp0_bd          <= 1'b0;
            cp0_epc_wdata   <= '0;
            cp0_badvaddr_we <= 1'b0;
            cp0_badvaddr    <= '0;
            cp0_eret        <= 1'b0;
        end else begin
            // Strobes are single-cycle: only the capture edge raises them.
            flush           <= 1'b0;
            cp0_exc_we      <= 1'b0;
            cp0_epc_we      <= 1'b0;
            cp0_badvaddr_we <= 1'b0;
            cp0_eret        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_valid && sel.hit) begin
                        state_q         <= StCommit;
                        eret_q          <= sel.is_eret;
                        flush           <= 1'b1;
                        stall_req       <= 1'b1;
                        cp0_eret        <= sel.is_eret;
                        cp0_exc_we      <= ~sel.is_eret;
                        // With EXL already set, EPC/BD keep the original fault.
                        cp0_epc_we      <= ~sel.is_eret & ~exl;
                        cp0_exc_code    <= sel.is_eret ? 5'h00 : sel.exc_code;
                        cp0_bd          <= ~sel.is_eret & mem_in_delay_slot;
                        cp0_epc_wdata   <= sel.is_eret ? '0 : epc_val;
                        cp0_badvaddr_we <= ~sel.is_eret & sel.use_badvaddr;
                        cp0_badvaddr    <= (!sel.is_eret && sel.use_badvaddr) ? bv_val : '0;
                    end
                end
                StCommit: begin
                    state_q        <= StRedirect;
                    stall_req      <= 1'b1;
                    redirect_valid <= 1'b1;
                    // ERET target is frozen here so later CP0 writes cannot move it.
                    redirect_pc    <= eret_q ? cp0_epc : EXC_VECTOR;
                    cp0_exc_code   <= '0;
                    cp0_bd         <= 1'b0;
                    cp0_epc_wdata  <= '0;
                    cp0_badvaddr   <= '0;
                end
                StRedirect: begin
                    if (if_ready) begin
                        state_q        <= StIdle;
                        eret_q         <= 1'b0;
                        stall_req      <= 1'b0;
                        redirect_valid <= 1'b0;
                        redirect_pc    <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: hand-derived vector table, reset corner case, then random events
// checked against a behavioural model of the priority/EPC rules.
module tb_exc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic [7:0]  mem_exc_type;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic        mem_is_store;
    logic [31:0] mem_badvaddr;
    logic [31:0] cp0_status;
    logic [7:0]  cp0_ip;
    logic [31:0] cp0_epc;
    logic        if_ready;
    logic        flush;
    logic        stall_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        cp0_exc_we;
    logic        cp0_epc_we;
    logic [4:0]  cp0_exc_code;
    logic        cp0_bd;
    logic [31:0] cp0_epc_wdata;
    logic        cp0_badvaddr_we;
    logic [31:0] cp0_badvaddr;
    logic        cp0_eret;

    int n_checks = 0;
    int n_fail   = 0;

    exc_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_valid         (mem_valid),
        .mem_exc_type      (mem_exc_type),
        .mem_pc            (mem_pc),
        .mem_in_delay_slot (mem_in_delay_slot),
        .mem_is_store      (mem_is_store),
        .mem_badvaddr      (mem_badvaddr),
        .cp0_status        (cp0_status),
        .cp0_ip            (cp0_ip),
        .cp0_epc           (cp0_epc),
        .if_ready          (if_ready),
        .flush             (flush),
        .stall_req         (stall_req),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .cp0_exc_we        (cp0_exc_we),
        .cp0_epc_we        (cp0_epc_we),
        .cp0_exc_code      (cp0_exc_code),
        .cp0_bd            (cp0_bd),
        .cp0_epc_wdata     (cp0_epc_wdata),
        .cp0_badvaddr_we   (cp0_badvaddr_we),
        .cp0_badvaddr      (cp0_badvaddr),
        .cp0_eret          (cp0_eret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        eret;
        logic        exc_we;
        logic        epc_we;
        logic        bd;
        logic        bv_we;
        logic [4:0]  code;
        logic [31:0] epc;
        logic [31:0] bv;
        logic [31:0] rpc;
    } exp_t;

    typedef struct {
        string       name;
        logic        valid;
        logic [7:0]  typ;
        logic [31:0] pc;
        logic        ds;
        logic        st;
        logic [31:0] bv;
        logic [31:0] status;
        logic [7:0]  ip;
        logic [31:0] epc;
        int          hold;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic hit, input logic eret, input logic exc_we,
                                    input logic epc_we, input logic bd, input logic bv_we,
                                    input logic [4:0] code, input logic [31:0] epc,
                                    input logic [31:0] bv, input logic [31:0] rpc);
        exp_t e;
        e.hit = hit; e.eret = eret; e.exc_we = exc_we; e.epc_we = epc_we; e.bd = bd;
        e.bv_we = bv_we; e.code = code; e.epc = epc; e.bv = bv; e.rpc = rpc;
        return e;
    endfunction

    function automatic vec_t mk_vec(input string name, input logic valid, input logic [7:0] typ,
                                    input logic [31:0] pc, input logic ds, input logic st,
                                    input logic [31:0] bv, input logic [31:0] status,
                                    input logic [7:0] ip, input logic [31:0] epc,
                                    input int hold, input exp_t e);
        vec_t v;
        v.name = name; v.valid = valid; v.typ = typ; v.pc = pc; v.ds = ds; v.st = st;
        v.bv = bv; v.status = status; v.ip = ip; v.epc = epc; v.hold = hold; v.e = e;
        return v;
    endfunction

    // Reference model: walk the priority list as a table, compute architectural results.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   bits [7]  = '{0, 1, 2, 3, 5, 4, 6};
        int   codes [7] = '{4, 10, 12, 13, 8, 9, 4};
        bit   found = 0;
        bit   exl   = v.status[1];
        bit   intp  = ((v.ip & v.status[15:8]) != 8'd0) && v.status[0] && !exl;
        e = '0;
        if (!v.valid) return e;
        if (intp) begin
            found  = 1;
            e.code = 5'd0;
        end
        for (int i = 0; i < 7; i++) begin
            if (!found && v.typ[bits[i]]) begin
                found  = 1;
                e.code = 5'(codes[i]);
                if (bits[i] == 6 && v.st) e.code = 5'd5;
                if (bits[i] == 0) begin e.bv_we = 1; e.bv = v.pc; end
                if (bits[i] == 6) begin e.bv_we = 1; e.bv = v.bv; end
            end
        end
        if (found) begin
            e.hit    = 1;
            e.exc_we = 1;
            e.epc_we = !exl;
            e.epc    = v.ds ? v.pc - 32'd4 : v.pc;
            e.bd     = v.ds;
            e.rpc    = 32'hBFC0_0380;
        end else if (v.typ[7]) begin
            e.hit  = 1;
            e.eret = 1;
            e.rpc  = v.epc;
        end
        return e;
    endfunction

    task automatic drive_junk();
        mem_valid         = 1'b1;
        mem_exc_type      = 8'($urandom);
        mem_pc            = $urandom;
        mem_in_delay_slot = 1'($urandom);
        mem_is_store      = 1'($urandom);
        mem_badvaddr      = $urandom;
        cp0_status        = $urandom;
        cp0_ip            = 8'($urandom);
    endtask

    task automatic check_idle(input string name);
        check({name, ".idle"},
              {flush, stall_req, redirect_valid, redirect_pc, cp0_exc_we, cp0_epc_we,
               cp0_exc_code, cp0_bd, cp0_epc_wdata, cp0_badvaddr_we, cp0_badvaddr, cp0_eret},
              128'd0);
    endtask

    task automatic check_redirect(input string name, input exp_t e);
        check({name, ".rvalid"}, 128'(redirect_valid), 128'd1);
        check({name, ".rpc"}, 128'(redirect_pc), 128'(e.rpc));
        check({name, ".rstall"}, 128'(stall_req), 128'd1);
        check({name, ".rstrobes"},
              128'({flush, cp0_exc_we, cp0_epc_we, cp0_badvaddr_we, cp0_eret}), 128'd0);
    endtask

    task automatic run_vec(input vec_t v);
        mem_valid         = v.valid;
        mem_exc_type      = v.typ;
        mem_pc            = v.pc;
        mem_in_delay_slot = v.ds;
        mem_is_store      = v.st;
        mem_badvaddr      = v.bv;
        cp0_status        = v.status;
        cp0_ip            = v.ip;
        cp0_epc           = v.epc;
        if_ready          = 1'b0;
        @(posedge clk); #1;
        if (!v.e.hit) begin
            mem_valid = 1'b0;
            @(negedge clk);
            check_idle({v.name, ".noevent"});
            return;
        end
        drive_junk();
        if_ready = 1'($urandom);
        @(negedge clk);
        check({v.name, ".flush"}, 128'({flush, stall_req, redirect_valid}), 128'b110);
        check({v.name, ".exc_we"}, 128'(cp0_exc_we), 128'(v.e.exc_we));
        check({v.name, ".epc_we"}, 128'(cp0_epc_we), 128'(v.e.epc_we));
        check({v.name, ".bv_we"}, 128'(cp0_badvaddr_we), 128'(v.e.bv_we));
        check({v.name, ".eret"}, 128'(cp0_eret), 128'(v.e.eret));
        if (v.e.exc_we) check({v.name, ".code"}, 128'(cp0_exc_code), 128'(v.e.code));
        if (v.e.epc_we) begin
            check({v.name, ".epc"}, 128'(cp0_epc_wdata), 128'(v.e.epc));
            check({v.name, ".bd"}, 128'(cp0_bd), 128'(v.e.bd));
        end
        if (v.e.bv_we) check({v.name, ".bv"}, 128'(cp0_badvaddr), 128'(v.e.bv));
        @(posedge clk); #1;
        if_ready = 1'b0;
        cp0_epc  = $urandom;  // must not disturb a latched ERET target
        drive_junk();
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            check_redirect(v.name, v.e);
            @(posedge clk); #1;
            drive_junk();
        end
        if_ready = 1'b1;
        @(negedge clk);
        check_redirect(v.name, v.e);
        @(posedge clk); #1;
        if_ready  = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        check_idle({v.name, ".exit"});
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_n             = 1'b1;
        mem_valid         = 1'b0;
        mem_exc_type      = 8'h00;
        mem_pc            = 32'h0;
        mem_in_delay_slot = 1'b0;
        mem_is_store      = 1'b0;
        mem_badvaddr      = 32'h0;
        cp0_status        = 32'h0;
        cp0_ip            = 8'h00;
        cp0_epc           = 32'h0;
        if_ready          = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle("reset_async");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_state");

        //                name           v  typ    pc            ds st bv            status        ip     epc           hold
        tbl.push_back(mk_vec("sys",      1, 8'h20, 32'h8000_0100, 0, 0, 32'h0,       32'h0,        8'h00, 32'h0,        1,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h08, 32'h8000_0100, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("ov_ds",    1, 8'h04, 32'h8000_0204, 1, 0, 32'h0,       32'h0,        8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 1, 0, 5'h0c, 32'h8000_0200, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("ri_eret",  1, 8'h82, 32'h8000_0300, 0, 0, 32'h0,       32'h0,        8'h00, 32'h8000_0040, 0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h0a, 32'h8000_0300, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("eret",     1, 8'h80, 32'h8000_0310, 0, 0, 32'h0,       32'h0,        8'h00, 32'h8000_0040, 2,
            mk_exp(1, 1, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 32'h8000_0040)));
        tbl.push_back(mk_vec("int",      1, 8'h00, 32'h8000_0500, 0, 0, 32'h0,       32'h0000_0401, 8'h04, 32'h0,       0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h00, 32'h8000_0500, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("int_exl",  1, 8'h00, 32'h8000_0500, 0, 0, 32'h0,       32'h0000_0403, 8'h04, 32'h0,       0,
            mk_exp(0, 0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk_vec("sys_exl",  1, 8'h20, 32'h8000_0510, 0, 0, 32'h0,       32'h0000_0403, 8'h04, 32'h0,       0,
            mk_exp(1, 0, 1, 0, 0, 0, 5'h08, 32'h8000_0510, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("ades",     1, 8'h40, 32'h8000_0700, 0, 1, 32'h0000_1001, 32'h0,       8'h00, 32'h0,        5,
            mk_exp(1, 0, 1, 1, 0, 1, 5'h05, 32'h8000_0700, 32'h0000_1001, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("adel",     1, 8'h40, 32'h8000_0710, 0, 0, 32'h0000_2002, 32'h0,       8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 0, 1, 5'h04, 32'h8000_0710, 32'h0000_2002, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("if_adel",  1, 8'h7f, 32'h8000_0601, 0, 1, 32'h0000_3003, 32'h0,       8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 0, 1, 5'h04, 32'h8000_0601, 32'h8000_0601, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("invalid",  0, 8'h20, 32'h8000_0800, 0, 0, 32'h0,       32'h0000_0401, 8'h04, 32'h0,       0,
            mk_exp(0, 0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 32'h0)));
        tbl.push_back(mk_vec("tp",       1, 8'h38, 32'h8000_0900, 0, 0, 32'h0,       32'h0,        8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h0d, 32'h8000_0900, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("bp",       1, 8'h50, 32'h8000_0904, 1, 0, 32'h0,       32'h0,        8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 1, 0, 5'h09, 32'h8000_0900, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("int_if",   1, 8'h01, 32'h8000_0a00, 0, 0, 32'h0,       32'h0000_8001, 8'h80, 32'h0,       0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h00, 32'h8000_0a00, 32'h0, 32'hBFC0_0380)));
        tbl.push_back(mk_vec("ov_tp",    1, 8'h0c, 32'h8000_0b00, 0, 0, 32'h0,       32'h0,        8'h00, 32'h0,        0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h0c, 32'h8000_0b00, 32'h0, 32'hBFC0_0380)));

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset while holding a redirect: outputs drop without a clock edge.
        mem_valid    = 1'b1;
        mem_exc_type = 8'h20;
        mem_pc       = 32'h8000_0c00;
        cp0_status   = 32'h0;
        if_ready     = 1'b0;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid.rvalid", 128'(redirect_valid), 128'd1);
        #2 rst_n = 1'b0;
        #1 check_idle("rst_mid.async");
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle("rst_mid.after");
        run_vec(mk_vec("post_rst", 1, 8'h02, 32'h8000_0d00, 0, 0, 32'h0, 32'h0, 8'h00, 32'h0, 0,
            mk_exp(1, 0, 1, 1, 0, 0, 5'h0a, 32'h8000_0d00, 32'h0, 32'hBFC0_0380)));

        // Random events against the model.
        for (int n = 0; n < 60; n++) begin
            rv.name  = $sformatf("rnd%0d", n);
            rv.valid = ($urandom_range(3) != 0);
            case ($urandom_range(2))
                0:       rv.typ = 8'(1 << $urandom_range(7));
                1:       rv.typ = 8'($urandom);
                default: rv.typ = 8'h00;
            endcase
            rv.pc     = {$urandom} & 32'hFFFF_FFFC;
            rv.ds     = 1'($urandom);
            rv.st     = 1'($urandom);
            rv.bv     = $urandom;
            rv.status = {16'h0, 8'($urandom), 6'h0, ($urandom_range(3) == 0), 1'($urandom)};
            rv.ip     = 8'($urandom);
            rv.epc    = $urandom;
            rv.hold   = $urandom_range(2);
            rv.e      = model(rv);
            run_vec(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
